tlb_multiport: RTL and testbench
================================

TLB_MULTIPORT -- requirements
Module: tlb_multiport

Interface
REQ-001 SHALL have parameter TLB_ENTRY_NUM, default 32, TLB entry count (power of 2, 4..64).
REQ-002 SHALL have parameter PORT_NUM, default 2, number of independent lookup ports (1..4).
REQ-003 SHALL have ports: clk  input  1  clock. The block uses one clock.
REQ-004 SHALL have ports: rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have ports: flush  input  1  drops all in-flight lookup responses.
REQ-006 SHALL have ports: csr  input  csr_t  crmd (DA/PG/PLV/DATF/DATM), asid, dmw0, dmw1.
REQ-007 SHALL have ports: req_valid_i  input  PORT_NUM  lookup request per port.
REQ-008 SHALL have ports: va_i  input  PORT_NUM x 32  virtual address per port.
REQ-009 SHALL have ports: mem_type_i  input  PORT_NUM x 2  _MEM_FETCH/_MEM_LOAD/_MEM_STORE.
REQ-010 SHALL have ports: resp_valid_o, pa_o, mat_o, ecode_o  output  PORT_NUM x (1, 32, 2, 6)  registered result.
REQ-011 SHALL have ports: tlb_write_req_i  input  tlb_write_req_t  one-hot index write plus entry.
REQ-012 SHALL have ports: fill_i  input  1  write the entry at fill_idx_o (overrides one-hot).
REQ-013 SHALL have ports: fill_idx_o  output  log2(TLB_ENTRY_NUM)  current replacement index.
REQ-014 SHALL have ports: inv_valid_i, inv_op_i[2:0], inv_asid_i[9:0], inv_va_i[31:0]  input  INVTLB command.
REQ-015 SHALL have ports: srch_valid_i  input  1; srch_hit_o  output  1; srch_idx_o  output  log2(TLB_ENTRY_NUM)  TLBSRCH on csr.tlbehi/asid.
REQ-016 SHALL have ports: rd_idx_i  input  log2(TLB_ENTRY_NUM); tlb_entry_o  output  tlb_entry_t  TLBRD data, registered.

Function
REQ-017 SHALL match an entry when e=1, (g=1 or asid==csr.asid), and VPPN matches: huge_page compares va[31:22] to vppn[18:9], else va[31:13] to vppn.
REQ-018 SHALL select value half by va[21] (huge) or va[12] (4KB); PA = {ppn[19:9], va[20:0]} (huge) or {ppn, va[11:0]} (4KB).
REQ-019 SHALL prioritise translation modes: DA -> pa=va, mat=DATF (fetch) else DATM; else DMW0 hit, then DMW1 hit (vseg==va[31:29], PLV allowed) -> {pseg, va[28:0]}; else TLB.
REQ-020 SHALL report TLB faults in priority order: no hit -> TLBR; v=0 -> PIF/PIL/PIS by type; PLV>plv -> PPI; store with d=0 -> PME; resp pa/mat undefined when ecode!=0.
REQ-021 SHALL produce each port's response exactly 1 cycle after req_valid_i, ports independent, no backpressure; resp_valid_o=0 the cycle after no request.
REQ-022 SHALL clear all resp_valid_o on flush, effective the next edge; a request in the flush cycle gets no response.
REQ-023 SHALL make writes, fills and invalidates visible from the following cycle; lookups in the same cycle see old contents.
REQ-024 SHALL, for fill_idx_o, implement a free-running counter incremented every cycle, wrapping TLB_ENTRY_NUM-1 -> 0.
REQ-025 SHALL clear e in one cycle per inv_op: 0/1 all; 2 g=1; 3 g=0; 4 g=0 and asid match; 5 g=0, asid and VA match; 6 (g=1 or asid match) and VA match; ops 7 ignored.
REQ-026 SHALL, when write/fill and invalidate coincide, apply invalidate to other entries and the write at its index (write wins).
REQ-027 SHALL register srch_hit_o/srch_idx_o 1 cycle after srch_valid_i; multiple hits give lowest index; no hit gives idx 0.
REQ-028 SHALL register tlb_entry_o = entry[rd_idx_i] every cycle.

Reset
REQ-029 SHALL, on rst_n low (asynchronous), clear all entry e bits, resp_valid_o, ecode_o, pa_o, mat_o, srch_hit_o, srch_idx_o, fill_idx_o to 0; reset mid-lookup SHALL produce no response.

Verification
REQ-030 SHALL verify: 4KB entry vppn=0x00040, asid=5, ppn=0x12345 odd half v=1,d=1; load va=0x00081ABC, asid=5 on port 1 -> next cycle pa=0x12345ABC, ecode 0.
REQ-031 SHALL verify: huge entry vppn[18:9]=0x3, ppn=0x80000; both ports look up va=0x00D01234 same cycle -> both pa=0x80101234.
REQ-032 SHALL verify: store to matching entry with d=0 -> ecode PME; unmatched va -> TLBR; PLV3 to plv0 page -> PPI.
REQ-033 SHALL verify: inv_op=4 asid=5 with entries g=1 asid5 and g=0 asid5 -> only g=0 entry misses afterwards; same-cycle write at index 3 survives.
REQ-034 SHALL verify: fill_idx_o wraps 31->0; fill at 31 writes index 31; flush with both req_valid -> no resp_valid next cycle.
REQ-035 SHALL verify: rst_n low asynchronously mid-lookup -> resp_valid_o 0 immediately, all lookups TLBR after release.

Source files
------------

// File: rtl/tlb_multiport.sv
// Multi-port TLB: fully associative entries, per-port DA/DMW/TLB translation,
// INVTLB, TLBSRCH, TLBRD and a free-running fill index for TLBFILL.
package tlb_pkg;
   typedef enum logic [1:0] {MEM_FETCH = 2'd0, MEM_LOAD = 2'd1, MEM_STORE = 2'd2} mem_type_e;

   localparam logic [5:0] ECODE_NONE = 6'h00;
   localparam logic [5:0] ECODE_PIL  = 6'h01;
   localparam logic [5:0] ECODE_PIS  = 6'h02;
   localparam logic [5:0] ECODE_PIF  = 6'h03;
   localparam logic [5:0] ECODE_PME  = 6'h04;
   localparam logic [5:0] ECODE_PPI  = 6'h07;
   localparam logic [5:0] ECODE_TLBR = 6'h3f;

   typedef struct packed {
      logic       da;
      logic       pg;
      logic [1:0] plv;
      logic [1:0] datf;
      logic [1:0] datm;
   } crmd_t;

   typedef struct packed {
      logic [2:0] vseg;
      logic [2:0] pseg;
      logic [1:0] mat;
      logic       plv3;
      logic       plv0;
   } dmw_t;

   typedef struct packed {
      crmd_t       crmd;
      logic [9:0]  asid;
      logic [18:0] tlbehi;
      dmw_t        dmw0;
      dmw_t        dmw1;
   } csr_t;

   typedef struct packed {
      logic [19:0] ppn;
      logic [1:0]  plv;
      logic [1:0]  mat;
      logic        d;
      logic        v;
   } tlb_half_t;

   typedef struct packed {
      logic [18:0]     vppn;
      logic            huge_page;
      logic            g;
      logic [9:0]      asid;
      tlb_half_t [1:0] half;
   } tlb_body_t;

   typedef struct packed {
      logic      e;
      tlb_body_t body;
   } tlb_entry_t;

   typedef struct packed {
      logic [63:0] idx_onehot;
      tlb_entry_t  entry;
   } tlb_write_req_t;
endpackage

module tlb_multiport
   import tlb_pkg::*;
#(
   parameter int TLB_ENTRY_NUM = 32,
   parameter int PORT_NUM      = 2,
   localparam int IDX_W        = $clog2(TLB_ENTRY_NUM)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         flush,
   input  csr_t                         csr,
   input  logic [PORT_NUM-1:0]          req_valid_i,
   input  logic [PORT_NUM-1:0][31:0]    va_i,
   input  logic [PORT_NUM-1:0][1:0]     mem_type_i,
   output logic [PORT_NUM-1:0]          resp_valid_o,
   output logic [PORT_NUM-1:0][31:0]    pa_o,
   output logic [PORT_NUM-1:0][1:0]     mat_o,
   output logic [PORT_NUM-1:0][5:0]     ecode_o,
   input  tlb_write_req_t               tlb_write_req_i,
   input  logic                         fill_i,
   output logic [IDX_W-1:0]             fill_idx_o,
   input  logic                         inv_valid_i,
   input  logic [2:0]                   inv_op_i,
   input  logic [9:0]                   inv_asid_i,
   input  logic [31:0]                  inv_va_i,
   input  logic                         srch_valid_i,
   output logic                         srch_hit_o,
   output logic [IDX_W-1:0]             srch_idx_o,
   input  logic [IDX_W-1:0]             rd_idx_i,
   output tlb_entry_t                   tlb_entry_o
);

   tlb_body_t                  body_q [TLB_ENTRY_NUM];
   logic [TLB_ENTRY_NUM-1:0]   e_q;
   logic [TLB_ENTRY_NUM-1:0]   wr_sel;
   logic [TLB_ENTRY_NUM-1:0]   inv_hit;
   logic [PORT_NUM-1:0][31:0]  pa_d;
   logic [PORT_NUM-1:0][1:0]   mat_d;
   logic [PORT_NUM-1:0][5:0]   ecode_d;
   logic                       srch_hit_d;
   logic [IDX_W-1:0]           srch_idx_d;

   function automatic logic vppn_match(tlb_body_t b, logic [18:0] vppn);
      return b.huge_page ? (b.vppn[18:9] == vppn[18:9]) : (b.vppn == vppn);
   endfunction

   function automatic logic dmw_hit(dmw_t d, logic [2:0] vseg, logic [1:0] plv);
      return (d.vseg == vseg) && ((plv == 2'd0 && d.plv0) || (plv == 2'd3 && d.plv3));
   endfunction

   // Only the low 13 VA bits of INVTLB and the one-hot bits above the table are ignored.
   if (TLB_ENTRY_NUM < 64) begin : g_unused_hi
      logic unused_bits;
      assign unused_bits = ^{inv_va_i[12:0], tlb_write_req_i.idx_onehot[63:TLB_ENTRY_NUM]};
   end else begin : g_unused_lo
      logic unused_bits;
      assign unused_bits = ^inv_va_i[12:0];
   end

   // A fill targets the replacement index and takes precedence over the one-hot write.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      wr_sel = '0;
      if (fill_i) wr_sel[fill_idx_o] = 1'b1;
      else        wr_sel = tlb_write_req_i.idx_onehot[TLB_ENTRY_NUM-1:0];
   end

   always_comb begin
      inv_hit = '0;
      for (int i = 0; i < TLB_ENTRY_NUM; i++) begin
         case (inv_op_i)
            3'd0, 3'd1: inv_hit[i] = 1'b1;
            3'd2:       inv_hit[i] = body_q[i].g;
            3'd3:       inv_hit[i] = !body_q[i].g;
            3'd4:       inv_hit[i] = !body_q[i].g && (body_q[i].asid == inv_asid_i);
            3'd5:       inv_hit[i] = !body_q[i].g && (body_q[i].asid == inv_asid_i)
                                     && vppn_match(body_q[i], inv_va_i[31:13]);
            3'd6:       inv_hit[i] = (body_q[i].g || (body_q[i].asid == inv_asid_i))
                                     && vppn_match(body_q[i], inv_va_i[31:13]);
            default:    inv_hit[i] = 1'b0;
         endcase
      end
   end

   // NOTE: the entry payload is plain storage with no reset; only the e bits need one.
   always_ff @(posedge clk) begin
      for (int i = 0; i < TLB_ENTRY_NUM; i++)
         if (wr_sel[i]) body_q[i] <= tlb_write_req_i.entry.body;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_q <= '0;
      end else begin
         for (int i = 0; i < TLB_ENTRY_NUM; i++) begin
            // NOTE: sequential state uses non-blocking assignment so all entries update together.
            if (wr_sel[i])                    e_q[i] <= tlb_write_req_i.entry.e;
            else if (inv_valid_i && inv_hit[i]) e_q[i] <= 1'b0;
         end
      end
   end

   always_comb begin : lookup
      logic      hit;
      logic      odd;
      tlb_body_t hb;
      tlb_half_t hh;
      pa_d    = '0;
      mat_d   = '0;
      ecode_d = '0;
      for (int p = 0; p < PORT_NUM; p++) begin
         hit = 1'b0;
         hb  = '0;
         // Scanning downwards leaves the lowest matching index selected.
         for (int i = TLB_ENTRY_NUM - 1; i >= 0; i--) begin
            if (e_q[i] && (body_q[i].g || body_q[i].asid == csr.asid)
                && vppn_match(body_q[i], va_i[p][31:13])) begin
               hit = 1'b1;
               hb  = body_q[i];
            end
         end
         odd = hb.huge_page ? va_i[p][21] : va_i[p][12];
         hh  = hb.half[odd];

         if (csr.crmd.da || !csr.crmd.pg) begin
            pa_d[p]  = va_i[p];
            mat_d[p] = (mem_type_i[p] == MEM_FETCH) ? csr.crmd.datf : csr.crmd.datm;
         end else if (dmw_hit(csr.dmw0, va_i[p][31:29], csr.crmd.plv)) begin
            pa_d[p]  = {csr.dmw0.pseg, va_i[p][28:0]};
            mat_d[p] = csr.dmw0.mat;
         end else if (dmw_hit(csr.dmw1, va_i[p][31:29], csr.crmd.plv)) begin
            pa_d[p]  = {csr.dmw1.pseg, va_i[p][28:0]};
            mat_d[p] = csr.dmw1.mat;
         end else begin
            pa_d[p]  = hb.huge_page ? {hh.ppn[19:9], va_i[p][20:0]} : {hh.ppn, va_i[p][11:0]};
            mat_d[p] = hh.mat;
            if (!hit) begin
               ecode_d[p] = ECODE_TLBR;
            end else if (!hh.v) begin
               case (mem_type_i[p])
                  MEM_FETCH: ecode_d[p] = ECODE_PIF;
                  MEM_STORE: ecode_d[p] = ECODE_PIS;
                  default:   ecode_d[p] = ECODE_PIL;
               endcase
            end else if (csr.crmd.plv > hh.plv) begin
               ecode_d[p] = ECODE_PPI;
            end else if (mem_type_i[p] == MEM_STORE && !hh.d) begin
               ecode_d[p] = ECODE_PME;
            end
         end
      end
   end

   always_comb begin
      srch_hit_d = 1'b0;
      srch_idx_d = '0;
      for (int i = TLB_ENTRY_NUM - 1; i >= 0; i--) begin
         if (e_q[i] && (body_q[i].g || body_q[i].asid == csr.asid)
             && vppn_match(body_q[i], csr.tlbehi)) begin
            srch_hit_d = 1'b1;
            srch_idx_d = IDX_W'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_valid_o <= '0;
         pa_o         <= '0;
         mat_o        <= '0;
         ecode_o      <= '0;
         fill_idx_o   <= '0;
         srch_hit_o   <= 1'b0;
         srch_idx_o   <= '0;
         tlb_entry_o  <= '0;
      end else begin
         resp_valid_o <= req_valid_i & ~{PORT_NUM{flush}};
         pa_o         <= pa_d;
         mat_o        <= mat_d;
         ecode_o      <= ecode_d;
         fill_idx_o   <= fill_idx_o + IDX_W'(1);
         if (srch_valid_i) begin
            srch_hit_o <= srch_hit_d;
            srch_idx_o <= srch_idx_d;
         end
         tlb_entry_o  <= '{e: e_q[rd_idx_i], body: body_q[rd_idx_i]};
      end
   end

endmodule

// File: tb/tb_tlb_multiport.sv
// Directed bench for tlb_multiport: translation modes, faults, INVTLB, search/read,
// fill index wrap, flush and asynchronous reset.
module tb_tlb_multiport;
   import tlb_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              flush;
   csr_t              csr;
   logic [1:0]        req_valid;
   logic [1:0][31:0]  va;
   logic [1:0][1:0]   mem_type;
   logic [1:0]        resp_valid;
   logic [1:0][31:0]  pa;
   logic [1:0][1:0]   mat;
   logic [1:0][5:0]   ecode;
   tlb_write_req_t    wr;
   logic              fill;
   logic [4:0]        fill_idx;
   logic              inv_valid;
   logic [2:0]        inv_op;
   logic [9:0]        inv_asid;
   logic [31:0]       inv_va;
   logic              srch_valid;
   logic              srch_hit;
   logic [4:0]        srch_idx;
   logic [4:0]        rd_idx;
   tlb_entry_t        rd_entry;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   tlb_multiport #(.TLB_ENTRY_NUM(32), .PORT_NUM(2)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .csr(csr),
      .req_valid_i(req_valid), .va_i(va), .mem_type_i(mem_type),
      .resp_valid_o(resp_valid), .pa_o(pa), .mat_o(mat), .ecode_o(ecode),
      .tlb_write_req_i(wr), .fill_i(fill), .fill_idx_o(fill_idx),
      .inv_valid_i(inv_valid), .inv_op_i(inv_op), .inv_asid_i(inv_asid), .inv_va_i(inv_va),
      .srch_valid_i(srch_valid), .srch_hit_o(srch_hit), .srch_idx_o(srch_idx),
      .rd_idx_i(rd_idx), .tlb_entry_o(rd_entry)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      req_valid     = '0;
      flush         = 1'b0;
      fill          = 1'b0;
      wr.idx_onehot = '0;
      inv_valid     = 1'b0;
      srch_valid    = 1'b0;
   endtask

   function automatic tlb_entry_t mk(logic [18:0] vppn, logic huge, logic g, logic [9:0] asid,
                                     logic odd, logic [19:0] ppn, logic [1:0] plv, logic d);
      tlb_entry_t en;
      en                    = '0;
      en.e                  = 1'b1;
      en.body.vppn          = vppn;
      en.body.huge_page     = huge;
      en.body.g             = g;
      en.body.asid          = asid;
      en.body.half[odd].ppn = ppn;
      en.body.half[odd].plv = plv;
      en.body.half[odd].mat = 2'd1;
      en.body.half[odd].d   = d;
      en.body.half[odd].v   = 1'b1;
      return en;
   endfunction

   task automatic write_entry(input int idx, input tlb_entry_t en);
      wr.idx_onehot = 64'd1 << idx;
      wr.entry      = en;
      tick();
      wr.idx_onehot = '0;
   endtask

   task automatic lookup(input int p, input logic [31:0] addr, input logic [1:0] mt);
      req_valid[p] = 1'b1;
      va[p]        = addr;
      mem_type[p]  = mt;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      idle();
      repeat (3) @(posedge clk);
      #1;
      n_total++; if (resp_valid !== 2'b00) $display("FAIL reset_resp_valid: got %b expected 00", resp_valid); else n_pass++;
      n_total++; if (fill_idx !== 5'd0) $display("FAIL reset_fill_idx: got %0d expected 0", fill_idx); else n_pass++;
      n_total++; if (srch_hit !== 1'b0 || srch_idx !== 5'd0) $display("FAIL reset_srch: got %b/%0d expected 0/0", srch_hit, srch_idx); else n_pass++;
      n_total++; if (ecode !== '0 || pa !== '0) $display("FAIL reset_result: got %h/%h expected 0/0", ecode, pa); else n_pass++;
      #2 rst_n = 1'b1;
      tick();
   endtask

   task automatic test_4k_lookup;
      // Write and lookup in the same cycle: the lookup still sees the old (empty) table.
      wr.idx_onehot = 64'd1;
      wr.entry      = mk(19'h00040, 1'b0, 1'b0, 10'd5, 1'b1, 20'h12345, 2'd0, 1'b1);
      lookup(1, 32'h00081ABC, MEM_LOAD);
      tick();
      wr.idx_onehot = '0;
      n_total++; if (ecode[1] !== ECODE_TLBR) $display("FAIL write_same_cycle: got %h expected %h", ecode[1], ECODE_TLBR); else n_pass++;
      tick();
      idle();
      n_total++; if (resp_valid !== 2'b10) $display("FAIL 4k_valid: got %b expected 10", resp_valid); else n_pass++;
      n_total++; if (pa[1] !== 32'h12345ABC) $display("FAIL 4k_pa: got %h expected 12345abc", pa[1]); else n_pass++;
      n_total++; if (ecode[1] !== ECODE_NONE || mat[1] !== 2'd1) $display("FAIL 4k_ecode_mat: got %h/%0d expected 00/1", ecode[1], mat[1]); else n_pass++;
      tick();
      n_total++; if (resp_valid !== 2'b00) $display("FAIL no_req_valid: got %b expected 00", resp_valid); else n_pass++;
   endtask

   task automatic test_huge_dual;
      write_entry(1, mk(19'h00600, 1'b1, 1'b1, 10'd0, 1'b0, 20'h80000, 2'd0, 1'b1));
      lookup(0, 32'h00D01234, MEM_LOAD);
      lookup(1, 32'h00D01234, MEM_FETCH);
      tick();
      idle();
      n_total++; if (resp_valid !== 2'b11) $display("FAIL huge_valid: got %b expected 11", resp_valid); else n_pass++;
      n_total++; if (pa[0] !== 32'h80101234 || pa[1] !== 32'h80101234) $display("FAIL huge_pa: got %h/%h expected 80101234", pa[0], pa[1]); else n_pass++;
      n_total++; if (ecode !== '0) $display("FAIL huge_ecode: got %h expected 0", ecode); else n_pass++;
   endtask

   task automatic test_faults;
      write_entry(2, mk(19'h00100, 1'b0, 1'b1, 10'd0, 1'b0, 20'h00777, 2'd0, 1'b0));
      lookup(0, 32'h00200123, MEM_STORE);
      lookup(1, 32'h7FFFF000, MEM_LOAD);
      tick();
      n_total++; if (ecode[0] !== ECODE_PME) $display("FAIL pme: got %h expected %h", ecode[0], ECODE_PME); else n_pass++;
      n_total++; if (ecode[1] !== ECODE_TLBR) $display("FAIL tlbr_miss: got %h expected %h", ecode[1], ECODE_TLBR); else n_pass++;
      lookup(0, 32'h00201000, MEM_FETCH);
      lookup(1, 32'h00201000, MEM_STORE);
      tick();
      n_total++; if (ecode[0] !== ECODE_PIF || ecode[1] !== ECODE_PIS) $display("FAIL invalid_half: got %h/%h expected 03/02", ecode[0], ecode[1]); else n_pass++;
      idle();
      csr.crmd.plv = 2'd3;
      lookup(0, 32'h00200123, MEM_LOAD);
      tick();
      n_total++; if (ecode[0] !== ECODE_PPI) $display("FAIL ppi: got %h expected %h", ecode[0], ECODE_PPI); else n_pass++;
      csr.crmd.plv = 2'd0;
      csr.asid     = 10'd6;
      lookup(0, 32'h00200123, MEM_LOAD);
      lookup(1, 32'h00081ABC, MEM_LOAD);
      tick();
      n_total++; if (ecode[0] !== ECODE_NONE || pa[0] !== 32'h00777123) $display("FAIL global_hit: got %h/%h expected 00/00777123", ecode[0], pa[0]); else n_pass++;
      n_total++; if (ecode[1] !== ECODE_TLBR) $display("FAIL asid_miss: got %h expected %h", ecode[1], ECODE_TLBR); else n_pass++;
      csr.asid = 10'd5;
      idle();
   endtask

   task automatic test_da_dmw;
      csr.crmd.da   = 1'b1;
      csr.crmd.datf = 2'd1;
      csr.crmd.datm = 2'd2;
      lookup(0, 32'h12345678, MEM_FETCH);
      lookup(1, 32'h12345678, MEM_STORE);
      tick();
      n_total++; if (pa[0] !== 32'h12345678 || mat[0] !== 2'd1) $display("FAIL da_fetch: got %h/%0d expected 12345678/1", pa[0], mat[0]); else n_pass++;
      n_total++; if (mat[1] !== 2'd2 || ecode[1] !== ECODE_NONE) $display("FAIL da_store: got %0d/%h expected 2/00", mat[1], ecode[1]); else n_pass++;
      csr.crmd.da = 1'b0;
      csr.dmw0    = '{vseg: 3'd4, pseg: 3'd0, mat: 2'd1, plv3: 1'b0, plv0: 1'b1};
      csr.dmw1    = '{vseg: 3'd5, pseg: 3'd1, mat: 2'd0, plv3: 1'b1, plv0: 1'b1};
      lookup(0, 32'h90000010, MEM_LOAD);
      lookup(1, 32'hA0000020, MEM_LOAD);
      tick();
      n_total++; if (pa[0] !== 32'h10000010 || mat[0] !== 2'd1) $display("FAIL dmw0: got %h/%0d expected 10000010/1", pa[0], mat[0]); else n_pass++;
      n_total++; if (pa[1] !== 32'h20000020 || mat[1] !== 2'd0) $display("FAIL dmw1: got %h/%0d expected 20000020/0", pa[1], mat[1]); else n_pass++;
      csr.crmd.plv = 2'd3;
      tick();
      n_total++; if (ecode[0] !== ECODE_TLBR) $display("FAIL dmw_plv_block: got %h expected %h", ecode[0], ECODE_TLBR); else n_pass++;
      csr.crmd.plv = 2'd0;
      csr.dmw0     = '0;
      csr.dmw1     = '0;
      idle();
   endtask

   task automatic test_invtlb;
      write_entry(4, mk(19'h00200, 1'b0, 1'b1, 10'd5, 1'b0, 20'h00444, 2'd0, 1'b1));
      write_entry(5, mk(19'h00300, 1'b0, 1'b0, 10'd5, 1'b0, 20'h00555, 2'd0, 1'b1));
      inv_valid     = 1'b1;
      inv_op        = 3'd4;
      inv_asid      = 10'd5;
      inv_va        = '0;
      wr.idx_onehot = 64'd1 << 3;
      wr.entry      = mk(19'h00400, 1'b0, 1'b0, 10'd5, 1'b0, 20'h00ABC, 2'd0, 1'b1);
      tick();
      idle();
      lookup(0, 32'h00400000, MEM_LOAD);
      lookup(1, 32'h00600000, MEM_LOAD);
      tick();
      n_total++; if (ecode[0] !== ECODE_NONE) $display("FAIL inv_global_kept: got %h expected 00", ecode[0]); else n_pass++;
      n_total++; if (ecode[1] !== ECODE_TLBR) $display("FAIL inv_asid_removed: got %h expected %h", ecode[1], ECODE_TLBR); else n_pass++;
      lookup(0, 32'h00800010, MEM_LOAD);
      lookup(1, 32'h00081ABC, MEM_LOAD);
      tick();
      n_total++; if (ecode[0] !== ECODE_NONE || pa[0] !== 32'h00ABC010) $display("FAIL inv_write_wins: got %h/%h expected 00/00abc010", ecode[0], pa[0]); else n_pass++;
      n_total++; if (ecode[1] !== ECODE_TLBR) $display("FAIL inv_entry0_removed: got %h expected %h", ecode[1], ECODE_TLBR); else n_pass++;
      idle();
   endtask

   task automatic test_search_read;
      write_entry(7, mk(19'h00200, 1'b0, 1'b1, 10'd9, 1'b0, 20'h00777, 2'd0, 1'b1));
      csr.tlbehi = 19'h00200;
      srch_valid = 1'b1;
      tick();
      n_total++; if (srch_hit !== 1'b1 || srch_idx !== 5'd4) $display("FAIL srch_lowest: got %b/%0d expected 1/4", srch_hit, srch_idx); else n_pass++;
      csr.tlbehi = 19'h00300;
      tick();
      n_total++; if (srch_hit !== 1'b0 || srch_idx !== 5'd0) $display("FAIL srch_miss: got %b/%0d expected 0/0", srch_hit, srch_idx); else n_pass++;
      csr.tlbehi = 19'h00400;
      tick();
      n_total++; if (srch_hit !== 1'b1 || srch_idx !== 5'd3) $display("FAIL srch_idx3: got %b/%0d expected 1/3", srch_hit, srch_idx); else n_pass++;
      srch_valid = 1'b0;
      rd_idx     = 5'd3;
      tick();
      n_total++; if (rd_entry.e !== 1'b1 || rd_entry.body.half[0].ppn !== 20'h00ABC) $display("FAIL tlbrd_3: got %b/%h expected 1/00abc", rd_entry.e, rd_entry.body.half[0].ppn); else n_pass++;
      rd_idx = 5'd5;
      tick();
      n_total++; if (rd_entry.e !== 1'b0) $display("FAIL tlbrd_5: got %b expected 0", rd_entry.e); else n_pass++;
   endtask

   task automatic test_fill_flush;
      for (int k = 0; k < 40 && fill_idx !== 5'd31; k++) tick();
      n_total++; if (fill_idx !== 5'd31) $display("FAIL fill_reach_31: got %0d expected 31", fill_idx); else n_pass++;
      fill          = 1'b1;
      wr.idx_onehot = 64'd1 << 6;
      wr.entry      = mk(19'h00500, 1'b0, 1'b1, 10'd0, 1'b0, 20'h00FFF, 2'd0, 1'b1);
      tick();
      idle();
      n_total++; if (fill_idx !== 5'd0) $display("FAIL fill_wrap: got %0d expected 0", fill_idx); else n_pass++;
      rd_idx = 5'd31;
      tick();
      n_total++; if (rd_entry.e !== 1'b1 || rd_entry.body.vppn !== 19'h00500) $display("FAIL fill_at_31: got %b/%h expected 1/00500", rd_entry.e, rd_entry.body.vppn); else n_pass++;
      rd_idx = 5'd6;
      tick();
      n_total++; if (rd_entry.e !== 1'b0) $display("FAIL fill_overrides_onehot: got %b expected 0", rd_entry.e); else n_pass++;
      lookup(0, 32'h00A00004, MEM_LOAD);
      lookup(1, 32'h00A00004, MEM_LOAD);
      flush = 1'b1;
      tick();
      n_total++; if (resp_valid !== 2'b00) $display("FAIL flush_drop: got %b expected 00", resp_valid); else n_pass++;
      flush = 1'b0;
      tick();
      idle();
      n_total++; if (resp_valid !== 2'b11 || pa[0] !== 32'h00FFF004) $display("FAIL after_flush: got %b/%h expected 11/00fff004", resp_valid, pa[0]); else n_pass++;
   endtask

   task automatic test_async_reset;
      lookup(0, 32'h00800010, MEM_LOAD);
      tick();
      n_total++; if (resp_valid !== 2'b01) $display("FAIL pre_reset_valid: got %b expected 01", resp_valid); else n_pass++;
      #2 rst_n = 1'b0;
      #1;
      n_total++; if (resp_valid !== 2'b00 || fill_idx !== 5'd0 || pa !== '0) $display("FAIL async_reset: got %b/%0d/%h expected 00/0/0", resp_valid, fill_idx, pa); else n_pass++;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      idle();
      lookup(0, 32'h00800010, MEM_LOAD);
      lookup(1, 32'h00200123, MEM_LOAD);
      tick();
      idle();
      n_total++; if (ecode[0] !== ECODE_TLBR || ecode[1] !== ECODE_TLBR) $display("FAIL post_reset_tlbr: got %h/%h expected 3f/3f", ecode[0], ecode[1]); else n_pass++;
   endtask

   initial begin
      csr           = '0;
      csr.crmd.pg   = 1'b1;
      csr.asid      = 10'd5;
      va            = '0;
      mem_type      = '0;
      wr            = '0;
      inv_op        = '0;
      inv_asid      = '0;
      inv_va        = '0;
      rd_idx        = '0;
      test_reset();
      test_4k_lookup();
      test_huge_dual();
      test_faults();
      test_da_dmw();
      test_invtlb();
      test_search_read();
      test_fill_flush();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
